yutorina_bus_arbiter: RTL and testbench

YUTORINA_BUS_ARBITER -- requirements
Module: yutorina_bus_arbiter

---
 rtl/yutorina_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_yutorina_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_arbiter.sv
// rtl/yutorina_bus_arbiter.sv - four-master round-robin bus arbiter with shared-bus mux
// Optional watchdog: define YUTORINA_BUS_ARB_TIMEOUT_EN to revoke grants stalled on s_rdy_.
module yutorina_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_,
   input  logic        m1_req_,
   input  logic        m2_req_,
   input  logic        m3_req_,
   output logic        m0_grnt_,
   output logic        m1_grnt_,
   output logic        m2_grnt_,
   output logic        m3_grnt_,
   input  logic [29:0] m0_addr,
   input  logic [29:0] m1_addr,
   input  logic [29:0] m2_addr,
   input  logic [29:0] m3_addr,
   input  logic        m0_as_,
   input  logic        m1_as_,
   input  logic        m2_as_,
   input  logic        m3_as_,
   input  logic        m0_rw,
   input  logic        m1_rw,
   input  logic        m2_rw,
   input  logic        m3_rw,
   input  logic [31:0] m0_wr_data,
   input  logic [31:0] m1_wr_data,
   input  logic [31:0] m2_wr_data,
   input  logic [31:0] m3_wr_data,
   output logic [29:0] s_addr,
   output logic        s_as_,
   output logic        s_rw,
   output logic [31:0] s_wr_data,
   input  logic        s_rdy_,
   output logic        arb_timeout
);

   localparam logic BUS_READ = 1'b1;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t     r_state;
   logic [1:0] r_owner;
   logic [1:0] r_last;
   logic [3:0] r_grnt_n;

   logic [3:0] w_req;
   logic [3:0] w_others;
   logic       w_owner_req;
   logic       w_fire;
   logic       w_hold;
   logic [1:0] w_idle_pick;
   logic [1:0] w_hand_pick;

   // First requester scanning base+1, base+2, base+3, base.
   function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] req);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = base;
      for (int i = 4; i >= 1; i--) begin
         idx = base + 2'(i);
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction

   assign w_req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign w_owner_req = w_req[r_owner];
   assign w_others    = w_req & ~(4'b0001 << r_owner);
   assign w_idle_pick = rr_pick(r_last, w_req);
   assign w_hand_pick = rr_pick(r_owner, w_others);
   assign w_hold      = (r_state == ST_GRANT) && w_owner_req && !w_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= 2'd0;
         r_last   <= 2'd3;
         r_grnt_n <= 4'hF;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_req) begin
                  r_owner  <= w_idle_pick;
                  r_last   <= w_idle_pick;
                  r_grnt_n <= ~(4'b0001 << w_idle_pick);
                  r_state  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Release or revoke: the outgoing owner is never a candidate here.
               if (!w_hold) begin
                  if (|w_others) begin
                     r_owner  <= w_hand_pick;
                     r_last   <= w_hand_pick;
                     r_grnt_n <= ~(4'b0001 << w_hand_pick);
                  end else begin
                     r_last   <= r_owner;
                     r_grnt_n <= 4'hF;
                     r_state  <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_grnt_n <= 4'hF;
            end
         endcase
      end
   end

`ifdef YUTORINA_BUS_ARB_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_timeout;

   assign w_fire = (r_state == ST_GRANT) && (r_cnt == 8'(TIMEOUT_CYCLES));

   // Counts consecutive not-ready cycles of the current tenure; saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_fire;
         if (!w_hold || !s_rdy_)
            r_cnt <= 8'd0;
         else if (r_cnt != 8'(TIMEOUT_CYCLES))
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign arb_timeout = r_timeout;
`else
   logic w_unused_watchdog;

   assign w_fire            = 1'b0;
   assign arb_timeout       = 1'b0;
   assign w_unused_watchdog = s_rdy_ ^ (|8'(TIMEOUT_CYCLES));
`endif

   always_comb begin
      s_addr    = 30'd0;
      s_as_     = 1'b1;
      s_rw      = BUS_READ;
      s_wr_data = 32'd0;
      if (r_state == ST_GRANT) begin
         case (r_owner)
            2'd0: begin s_addr = m0_addr; s_as_ = m0_as_; s_rw = m0_rw; s_wr_data = m0_wr_data; end
            2'd1: begin s_addr = m1_addr; s_as_ = m1_as_; s_rw = m1_rw; s_wr_data = m1_wr_data; end
            2'd2: begin s_addr = m2_addr; s_as_ = m2_as_; s_rw = m2_rw; s_wr_data = m2_wr_data; end
            default: begin s_addr = m3_addr; s_as_ = m3_as_; s_rw = m3_rw; s_wr_data = m3_wr_data; end
         endcase
      end
   end

   assign m0_grnt_ = r_grnt_n[0];
   assign m1_grnt_ = r_grnt_n[1];
   assign m2_grnt_ = r_grnt_n[2];
   assign m3_grnt_ = r_grnt_n[3];

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb/tb_yutorina_bus_arbiter.sv - scoreboard bench for yutorina_bus_arbiter
module tb_yutorina_bus_arbiter;

   localparam int TO_LIMIT = 4;
`ifdef YUTORINA_BUS_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_n;
   logic [3:0]  as_n;
   logic [3:0]  rw;
   logic [29:0] m_addr [4];
   logic [31:0] m_wd   [4];
   logic        s_rdy_n;
   logic [3:0]  grnt_n;
   logic [29:0] s_addr;
   logic        s_as_n;
   logic        s_rw;
   logic [31:0] s_wd;
   logic        arb_to;

   always #5 clk = ~clk;

   yutorina_bus_arbiter #(.TIMEOUT_CYCLES(TO_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
      .m0_grnt_(grnt_n[0]), .m1_grnt_(grnt_n[1]), .m2_grnt_(grnt_n[2]), .m3_grnt_(grnt_n[3]),
      .m0_addr(m_addr[0]), .m1_addr(m_addr[1]), .m2_addr(m_addr[2]), .m3_addr(m_addr[3]),
      .m0_as_(as_n[0]), .m1_as_(as_n[1]), .m2_as_(as_n[2]), .m3_as_(as_n[3]),
      .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
      .m0_wr_data(m_wd[0]), .m1_wr_data(m_wd[1]), .m2_wr_data(m_wd[2]), .m3_wr_data(m_wd[3]),
      .s_addr(s_addr), .s_as_(s_as_n), .s_rw(s_rw), .s_wr_data(s_wd),
      .s_rdy_(s_rdy_n), .arb_timeout(arb_to)
   );

   typedef struct {
      logic [3:0]  grnt_n;
      logic        as_n;
      logic [29:0] addr;
      logic        rw;
      logic [31:0] wd;
      logic        to;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: owner is -1 when the bus is free.
   int mo_own, mo_last, mo_cnt;
   bit mo_to;

   function automatic int rr(input int base, input logic [3:0] mask);
      for (int k = 1; k <= 4; k++)
         if (mask[(base + k) % 4]) return (base + k) % 4;
      return -1;
   endfunction

   task automatic step(input logic [3:0] rq, input logic rdy, input logic r);
      exp_t       e;
      logic [3:0] act;
      logic [3:0] others;
      bit         fire;
      req_n = rq; s_rdy_n = rdy; rst = r;
      for (int m = 0; m < 4; m++) begin
         m_addr[m] = 30'($urandom);
         m_wd[m]   = $urandom;
         as_n[m]   = 1'($urandom);
         rw[m]     = 1'($urandom);
      end
      if (mo_own < 0) begin
         e.grnt_n = 4'hF; e.as_n = 1'b1; e.addr = '0; e.rw = 1'b1; e.wd = '0;
      end else begin
         e.grnt_n = ~(4'b0001 << mo_own);
         e.as_n = as_n[mo_own]; e.addr = m_addr[mo_own]; e.rw = rw[mo_own]; e.wd = m_wd[mo_own];
      end
      e.to = mo_to;
      q.push_back(e);

      act = ~rq;
      if (r) begin
         mo_own = -1; mo_last = 3; mo_cnt = 0; mo_to = 0;
      end else if (mo_own < 0) begin
         mo_to = 0; mo_cnt = 0;
         if (act != 0) begin mo_own = rr(mo_last, act); mo_last = mo_own; end
      end else begin
         fire  = TO_EN && (mo_cnt == TO_LIMIT);
         mo_to = fire;
         if (act[mo_own] && !fire) begin
            if (rdy == 1'b0) mo_cnt = 0;
            else if (mo_cnt < TO_LIMIT) mo_cnt = mo_cnt + 1;
         end else begin
            others = act;
            others[mo_own] = 1'b0;
            mo_last = mo_own;
            mo_cnt = 0;
            if (others != 0) begin mo_own = rr(mo_own, others); mo_last = mo_own; end
            else mo_own = -1;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (grnt_n !== e.grnt_n) begin
               bad++;
               $display("FAIL grant t=%0t got=%b want=%b", $time, grnt_n, e.grnt_n);
            end
            total++;
            if ({s_as_n, s_addr, s_rw, s_wd} !== {e.as_n, e.addr, e.rw, e.wd}) begin
               bad++;
               $display("FAIL bus t=%0t got as=%b a=%h rw=%b d=%h want as=%b a=%h rw=%b d=%h",
                        $time, s_as_n, s_addr, s_rw, s_wd, e.as_n, e.addr, e.rw, e.wd);
            end
            total++;
            if (arb_to !== e.to) begin
               bad++;
               $display("FAIL timeout t=%0t got=%b want=%b", $time, arb_to, e.to);
            end
         end
      end
   end

   initial begin : stim
      int         held [4];
      bit         done [4];
      logic [3:0] rq;
      int         guard;
      rst = 1'b1; req_n = 4'hF; s_rdy_n = 1'b0; as_n = 4'hF; rw = 4'hF;
      for (int m = 0; m < 4; m++) begin m_addr[m] = '0; m_wd[m] = '0; end
      mo_own = -1; mo_last = 3; mo_cnt = 0; mo_to = 0;
      @(posedge clk); #1;

      // Reset state, then single request from master 2
      step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1011, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);

      // All four request after reset; each releases after 3 granted cycles
      step(4'hF, 1'b0, 1'b1);
      for (int m = 0; m < 4; m++) begin held[m] = 0; done[m] = 0; end
      for (int c = 0; c < 18; c++) begin
         for (int m = 0; m < 4; m++) rq[m] = done[m];
         step(rq, 1'b0, 1'b0);
         for (int m = 0; m < 4; m++)
            if (mo_own == m && !done[m]) begin
               held[m]++;
               if (held[m] == 3) done[m] = 1;
            end
      end

      // m1 releases and re-requests while m3 waits: m3 first, then m1
      step(4'hF, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b1101, 1'b0, 1'b0);
      step(4'b0111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0101, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1101, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);

      // Reset while m0 owns, then m0 and m2 contend
      for (int i = 0; i < 2; i++) step(4'b1110, 1'b0, 1'b0);
      step(4'b1110, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);

      // m1 owns with s_rdy_ stuck high while m2 waits
      step(4'hF, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step((i == 0) ? 4'b1101 : 4'b1001, 1'b1, 1'b0);
      step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);

      // Same contention with s_rdy_ low every third cycle
      step(4'hF, 1'b0, 1'b1);
      step(4'b1101, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step(4'b1001, (i % 3 == 2) ? 1'b0 : 1'b1, 1'b0);
      step(4'hF, 1'b0, 1'b0);

      // Random traffic
      rq = 4'hF;
      for (int c = 0; c < 1500; c++) begin
         for (int m = 0; m < 4; m++)
            if ($urandom_range(0, 3) == 0) rq[m] = ~rq[m];
         step(rq, ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 99) == 0));
      end
      step(4'hF, 1'b0, 1'b0);

      guard = 0;
      while (q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
